mt_frame_counter: RTL and testbench

//  MT Frame Count register (MTFC) and its transfer-count sequencer, upstream of MTTC.

---
 rtl/mt_frame_counter_pkg.sv | 16 +
 rtl/mt_frame_counter_if.sv | 21 ++
 rtl/mt_fc_cnt.sv | 25 ++
 rtl/mt_frame_counter.sv | 78 +++++++
 tb/tb_mt_frame_counter.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/mt_frame_counter_pkg.sv
// Shared encodings for the MT frame counter: transfer modes, sequencer states, field helper.
package mt_frame_counter_pkg;
  localparam int FC_WIDTH = 16;

  localparam logic [1:0] MT_MODE_WR  = 2'd0;
  localparam logic [1:0] MT_MODE_RD  = 2'd1;
  localparam logic [1:0] MT_MODE_SPC = 2'd2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic [FC_WIDTH-1:0] mt_fc_field(input logic [35:0] d);
    return d[FC_WIDTH-1:0];
  endfunction
endpackage

// File: rtl/mt_frame_counter_if.sv
// Host/data-path/transport side of the MTFC: event strobes in, count and status out.
interface mt_frame_counter_if;
  import mt_frame_counter_pkg::*;
  logic                mtINIT, mtPRESET, mtWRFC, mtGO;
  logic [35:0]         mtDATAI;
  logic [1:0]          mtMODE;
  logic                mtFRAME, mtREC, mtEOR, mtSTOP;
  logic [FC_WIDTH-1:0] mtFC;
  logic                mtFCS, mtFCZ, mtBUSY, mtDONE, mtFCE, mtRMR;

  modport master (
    output mtINIT, mtPRESET, mtWRFC, mtGO, mtDATAI, mtMODE,
           mtFRAME, mtREC, mtEOR, mtSTOP,
    input  mtFC, mtFCS, mtFCZ, mtBUSY, mtDONE, mtFCE, mtRMR
  );
  modport slave (
    input  mtINIT, mtPRESET, mtWRFC, mtGO, mtDATAI, mtMODE,
           mtFRAME, mtREC, mtEOR, mtSTOP,
    output mtFC, mtFCS, mtFCZ, mtBUSY, mtDONE, mtFCE, mtRMR
  );
endinterface

// File: rtl/mt_fc_cnt.sv
// Loadable incrementer for MTFC; co reports the 17th bit of an increment that is taken.
module mt_fc_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         inc,
  input  logic         hold,
  output logic [W-1:0] cnt,
  output logic         co
);
  logic step;
  assign step = inc & ~hold;
  assign co   = step & (&cnt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (load) cnt <= din;
    else if (step) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/mt_frame_counter.sv
// MTFC register and transfer-count sequencer (IDLE/RUN/DONE) feeding mtFCS to MTTC.
module mt_frame_counter
  import mt_frame_counter_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  mt_frame_counter_if.slave  bus
);
  logic [1:0] state, mode;
  logic       fcs, fce, rmr;
  logic       is_rd, is_spc, run, load, go, ev, co;
  logic [FC_WIDTH-1:0] fc;

  assign run    = (state == ST_RUN);
  assign is_spc = (mode == MT_MODE_SPC);
  assign is_rd  = (mode == MT_MODE_RD) || (mode == 2'd3);
  assign load   = (state == ST_IDLE) && bus.mtWRFC && !bus.mtINIT;
  assign go     = (state == ST_IDLE) && bus.mtGO && !bus.mtWRFC && !bus.mtINIT;
  assign ev     = run && (is_spc ? bus.mtREC : bus.mtFRAME);

  // In read mode fce doubles as the saturate flag: once the count wraps, it stays at zero.
  mt_fc_cnt #(.W(FC_WIDTH)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (bus.mtINIT),
    .load(load),
    .din (mt_fc_field(bus.mtDATAI)),
    .inc (ev),
    .hold(fce),
    .cnt (fc),
    .co  (co)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      mode  <= MT_MODE_WR;
      fcs   <= 1'b0;
      fce   <= 1'b0;
      rmr   <= 1'b0;
    end else if (bus.mtINIT) begin
      state <= ST_IDLE;
      mode  <= MT_MODE_WR;
      fcs   <= 1'b0;
      fce   <= 1'b0;
      rmr   <= 1'b0;
    end else begin
      rmr <= bus.mtWRFC && (state != ST_IDLE);
      if (bus.mtPRESET) fcs <= 1'b0;
      if (load) begin
        fcs <= 1'b1;
        fce <= 1'b0;
      end
      case (state)
        ST_IDLE: if (go) begin
          state <= ST_RUN;
          mode  <= bus.mtMODE;
          fce   <= 1'b0;
        end
        ST_RUN: begin
          if (co && is_rd) fce <= 1'b1;
          // Count is applied first; stop, wrap or end-of-record then close the transfer.
          if (bus.mtSTOP || (co && !is_rd) || (is_rd && bus.mtEOR))
            state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.mtFC   = fc;
  assign bus.mtFCZ  = (fc == '0);
  assign bus.mtFCS  = fcs;
  assign bus.mtFCE  = fce;
  assign bus.mtRMR  = rmr;
  assign bus.mtBUSY = (state != ST_IDLE);
  assign bus.mtDONE = (state == ST_DONE);
endmodule

// File: tb/tb_mt_frame_counter.sv
// Directed bench for mt_frame_counter: load, count, wrap, saturate, stop, refusal and reset cases.
module tb_mt_frame_counter;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  mt_frame_counter_if bus();
  mt_frame_counter dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.mtINIT = 0; bus.mtPRESET = 0; bus.mtWRFC = 0; bus.mtGO = 0;
    bus.mtDATAI = '0; bus.mtMODE = 2'd0; bus.mtFRAME = 0; bus.mtREC = 0;
    bus.mtEOR = 0; bus.mtSTOP = 0;
  endtask

  task automatic load_fc(input logic [15:0] v);
    bus.mtDATAI = {20'h0, v}; bus.mtWRFC = 1; step(); bus.mtWRFC = 0;
  endtask

  task automatic start(input logic [1:0] m);
    bus.mtMODE = m; bus.mtGO = 1; step(); bus.mtGO = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 0;
    #12;
    checks++;
    if (bus.mtFC !== 16'h0 || bus.mtFCS !== 0 || bus.mtFCZ !== 1 || bus.mtBUSY !== 0 ||
        bus.mtDONE !== 0 || bus.mtFCE !== 0 || bus.mtRMR !== 0) begin
      failures++;
      $display("FAIL reset: fc=%h fcs=%b fcz=%b busy=%b done=%b fce=%b rmr=%b, want 0000 0 1 0 0 0 0",
               bus.mtFC, bus.mtFCS, bus.mtFCZ, bus.mtBUSY, bus.mtDONE, bus.mtFCE, bus.mtRMR);
    end
    @(negedge clk); rst = 1;
    step();
  endtask

  task automatic test_write();
    load_fc(16'o177775);
    checks++;
    if (bus.mtFC !== 16'hFFFD || bus.mtFCS !== 1) begin
      failures++; $display("FAIL wr_load: fc=%h fcs=%b want fffd 1", bus.mtFC, bus.mtFCS);
    end
    start(2'd0);
    checks++;
    if (bus.mtBUSY !== 1) begin failures++; $display("FAIL wr_busy: got %b want 1", bus.mtBUSY); end
    bus.mtFRAME = 1; step(); step();
    checks++;
    if (bus.mtFC !== 16'hFFFF || bus.mtDONE !== 0) begin
      failures++; $display("FAIL wr_2nd: fc=%h done=%b want ffff 0", bus.mtFC, bus.mtDONE);
    end
    step(); bus.mtFRAME = 0;
    checks++;
    if (bus.mtFC !== 16'h0 || bus.mtDONE !== 1 || bus.mtFCE !== 0 || bus.mtFCZ !== 1) begin
      failures++;
      $display("FAIL wr_done: fc=%h done=%b fce=%b fcz=%b want 0000 1 0 1", bus.mtFC, bus.mtDONE, bus.mtFCE, bus.mtFCZ);
    end
    step();
    checks++;
    if (bus.mtDONE !== 0 || bus.mtBUSY !== 0) begin
      failures++; $display("FAIL wr_idle: done=%b busy=%b want 0 0", bus.mtDONE, bus.mtBUSY);
    end
  endtask

  task automatic test_read_long();
    load_fc(16'o177776);
    start(2'd1);
    bus.mtFRAME = 1; step(); step();
    checks++;
    if (bus.mtFC !== 16'h0 || bus.mtFCE !== 1 || bus.mtBUSY !== 1 || bus.mtDONE !== 0) begin
      failures++;
      $display("FAIL rd_wrap: fc=%h fce=%b busy=%b done=%b want 0000 1 1 0", bus.mtFC, bus.mtFCE, bus.mtBUSY, bus.mtDONE);
    end
    step(); step(); step(); bus.mtFRAME = 0;
    checks++;
    if (bus.mtFC !== 16'h0 || bus.mtDONE !== 0) begin
      failures++; $display("FAIL rd_sat: fc=%h done=%b want 0000 0", bus.mtFC, bus.mtDONE);
    end
    bus.mtEOR = 1; step(); bus.mtEOR = 0;
    checks++;
    if (bus.mtDONE !== 1 || bus.mtFCE !== 1 || bus.mtFC !== 16'h0) begin
      failures++; $display("FAIL rd_eor: done=%b fce=%b fc=%h want 1 1 0000", bus.mtDONE, bus.mtFCE, bus.mtFC);
    end
    step();
    // Reserved mode 3 behaves as read: wrap does not finish, EOR does.
    load_fc(16'hFFFF);
    start(2'd3);
    bus.mtFRAME = 1; step(); bus.mtFRAME = 0;
    checks++;
    if (bus.mtFC !== 16'h0 || bus.mtFCE !== 1 || bus.mtDONE !== 0 || bus.mtBUSY !== 1) begin
      failures++;
      $display("FAIL m3_wrap: fc=%h fce=%b done=%b busy=%b want 0000 1 0 1", bus.mtFC, bus.mtFCE, bus.mtDONE, bus.mtBUSY);
    end
    bus.mtEOR = 1; step(); bus.mtEOR = 0;
    checks++;
    if (bus.mtDONE !== 1) begin failures++; $display("FAIL m3_eor: done=%b want 1", bus.mtDONE); end
    step();
    // Short record: EOR with count remaining, no error.
    load_fc(16'hFFF0);
    start(2'd1);
    bus.mtFRAME = 1; bus.mtEOR = 1; step(); bus.mtFRAME = 0; bus.mtEOR = 0;
    checks++;
    if (bus.mtDONE !== 1 || bus.mtFCE !== 0 || bus.mtFC !== 16'hFFF1) begin
      failures++; $display("FAIL rd_short: done=%b fce=%b fc=%h want 1 0 fff1", bus.mtDONE, bus.mtFCE, bus.mtFC);
    end
    step();
  endtask

  task automatic test_space_zero();
    int zhits = 0;
    int dhits = 0;
    load_fc(16'h0000);
    start(2'd2);
    checks++;
    if (bus.mtFCZ !== 1) begin failures++; $display("FAIL spc_start_fcz: got %b want 1", bus.mtFCZ); end
    bus.mtREC = 1;
    for (int i = 0; i < 65535; i++) begin
      step();
      if (bus.mtFCZ) zhits++;
      if (bus.mtDONE) dhits++;
    end
    checks++;
    if (zhits != 0 || dhits != 0 || bus.mtFC !== 16'hFFFF) begin
      failures++; $display("FAIL spc_mid: fcz_hits=%0d done_hits=%0d fc=%h want 0 0 ffff", zhits, dhits, bus.mtFC);
    end
    step(); bus.mtREC = 0;
    checks++;
    if (bus.mtDONE !== 1 || bus.mtFC !== 16'h0 || bus.mtFCZ !== 1) begin
      failures++; $display("FAIL spc_done: done=%b fc=%h fcz=%b want 1 0000 1", bus.mtDONE, bus.mtFC, bus.mtFCZ);
    end
    step();
  endtask

  task automatic test_rmr_preset();
    load_fc(16'h0010);
    start(2'd0);
    bus.mtDATAI = 36'h1234; bus.mtWRFC = 1; step(); bus.mtWRFC = 0;
    checks++;
    if (bus.mtRMR !== 1 || bus.mtFC !== 16'h0010) begin
      failures++; $display("FAIL rmr_pulse: rmr=%b fc=%h want 1 0010", bus.mtRMR, bus.mtFC);
    end
    step();
    checks++;
    if (bus.mtRMR !== 0) begin failures++; $display("FAIL rmr_clear: got %b want 0", bus.mtRMR); end
    bus.mtSTOP = 1; step(); bus.mtSTOP = 0; step();
    bus.mtPRESET = 1; step(); bus.mtPRESET = 0;
    checks++;
    if (bus.mtFCS !== 0 || bus.mtFC !== 16'h0010) begin
      failures++; $display("FAIL preset: fcs=%b fc=%h want 0 0010", bus.mtFCS, bus.mtFC);
    end
    load_fc(16'h1234);
    checks++;
    if (bus.mtFCS !== 1 || bus.mtFC !== 16'h1234 || bus.mtRMR !== 0) begin
      failures++; $display("FAIL idle_load: fcs=%b fc=%h rmr=%b want 1 1234 0", bus.mtFCS, bus.mtFC, bus.mtRMR);
    end
  endtask

  task automatic test_stop_and_load_go();
    load_fc(16'hFFF0);
    start(2'd0);
    bus.mtFRAME = 1; bus.mtSTOP = 1; step(); bus.mtFRAME = 0; bus.mtSTOP = 0;
    checks++;
    if (bus.mtFC !== 16'hFFF1 || bus.mtDONE !== 1) begin
      failures++; $display("FAIL stop: fc=%h done=%b want fff1 1", bus.mtFC, bus.mtDONE);
    end
    step();
    bus.mtDATAI = 36'h5; bus.mtWRFC = 1; bus.mtGO = 1; step(); bus.mtWRFC = 0; bus.mtGO = 0;
    checks++;
    if (bus.mtFC !== 16'h0005 || bus.mtBUSY !== 0) begin
      failures++; $display("FAIL load_go: fc=%h busy=%b want 0005 0", bus.mtFC, bus.mtBUSY);
    end
  endtask

  task automatic test_reset_midrun();
    int dhits = 0;
    load_fc(16'h0008);
    start(2'd0);
    bus.mtFRAME = 1; step(); bus.mtFRAME = 0;
    checks++;
    if (bus.mtFC !== 16'h0009) begin failures++; $display("FAIL mid_cnt: fc=%h want 0009", bus.mtFC); end
    #2 rst = 0; #1;
    checks++;
    if (bus.mtFC !== 16'h0 || bus.mtFCS !== 0 || bus.mtBUSY !== 0) begin
      failures++; $display("FAIL async_rst: fc=%h fcs=%b busy=%b want 0000 0 0", bus.mtFC, bus.mtFCS, bus.mtBUSY);
    end
    @(negedge clk); rst = 1;
    for (int i = 0; i < 3; i++) begin step(); if (bus.mtDONE) dhits++; end
    checks++;
    if (dhits != 0) begin failures++; $display("FAIL rst_nodone: done_hits=%0d want 0", dhits); end
    load_fc(16'h0100);
    start(2'd1);
    bus.mtINIT = 1; step(); bus.mtINIT = 0;
    checks++;
    if (bus.mtFC !== 16'h0 || bus.mtFCS !== 0 || bus.mtBUSY !== 0 || bus.mtDONE !== 0) begin
      failures++;
      $display("FAIL init: fc=%h fcs=%b busy=%b done=%b want 0000 0 0 0", bus.mtFC, bus.mtFCS, bus.mtBUSY, bus.mtDONE);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_long();
    test_space_zero();
    test_rmr_preset();
    test_stop_and_load_go();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
